// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, issues REQ/GNT fetches and buffers words in a prefetch FIFO for decode.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect target parks the unit in FAULT instead of aligning it.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        i_CLK,
  input  logic        i_RSTn,
  output logic        o_INSTR_REQ,
  output logic [31:0] o_INSTR_ADDR,
  input  logic        i_INSTR_GNT,
  input  logic [31:0] i_INSTR_RDATA,
  output logic        o_IR_VALID,
  output logic [31:0] o_IR,
  output logic [31:0] o_IR_PC,
  input  logic        i_IR_READY,
  input  logic        i_REDIRECT,
  input  logic [31:0] i_REDIRECT_PC,
  output logic        o_FETCH_FAULT
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {RUN, WAIT, FAULT} state_t;
  state_t state, state_n;
  logic [31:0] fpc, fpc_n, rpc, rpc_n, tgt;
  logic killed, killed_n, tgt_bad, rpc_bad, req, req_n, flt, flt_n, gnt, push, pop;
  logic [CW-1:0] count, count_n;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] mem_ir [DEPTH];
  logic [31:0] mem_pc [DEPTH];
  assign req = state == WAIT;
  assign flt = state == FAULT;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt = i_REDIRECT_PC;
  assign tgt_bad = |i_REDIRECT_PC[1:0];
  assign rpc_bad = |rpc[1:0];
  assign o_FETCH_FAULT = flt;
`else
  assign tgt = i_REDIRECT_PC & ~32'h3;
  assign tgt_bad = 1'b0;
  assign rpc_bad = 1'b0;
  assign o_FETCH_FAULT = 1'b0;
`endif
  assign gnt = i_INSTR_GNT & req;
  assign push = gnt & ~killed & ~i_REDIRECT;
  assign pop = o_IR_VALID & i_IR_READY & ~i_REDIRECT;
  assign o_INSTR_REQ = req;
  assign o_INSTR_ADDR = fpc;
  assign o_IR_VALID = count != '0;
  assign o_IR = o_IR_VALID ? mem_ir[rd_ptr] : '0;
  assign o_IR_PC = o_IR_VALID ? mem_pc[rd_ptr] : '0;
  // A redirect during an outstanding request defers the PC load to that request's grant.
  always_comb begin
    count_n = i_REDIRECT ? '0 : count + CW'(push) - CW'(pop);
    fpc_n = gnt ? fpc + 32'd4 : fpc;
    rpc_n = rpc;
    killed_n = killed & ~gnt;
    flt_n = flt;
    if (gnt && killed) begin
      flt_n = rpc_bad;
      fpc_n = rpc_bad ? fpc : rpc;
    end
    if (i_REDIRECT && req && !gnt) begin
      killed_n = 1'b1;
      rpc_n = tgt;
    end else if (i_REDIRECT) begin
      flt_n = tgt_bad;
      fpc_n = tgt_bad ? fpc_n : tgt;
    end
    req_n = (req & ~gnt) | (~flt_n & (count_n < CW'(DEPTH)));
    state_n = flt_n ? FAULT : req_n ? WAIT : RUN;
  end
  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      state <= RUN;
      fpc <= RESET_PC;
      rpc <= '0;
      killed <= 1'b0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_n;
      fpc <= fpc_n;
      rpc <= rpc_n;
      killed <= killed_n;
      count <= count_n;
      rd_ptr <= i_REDIRECT ? '0 : rd_ptr + AW'(pop);
      wr_ptr <= i_REDIRECT ? '0 : wr_ptr + AW'(push);
    end
  end
  always_ff @(posedge i_CLK) begin
    if (push) begin
      mem_ir[wr_ptr] <= i_INSTR_RDATA;
      mem_pc[wr_ptr] <= fpc;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch against a grant-every-other-cycle responder.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst_n, req, gnt, gnt_q, stray, valid, ready, redirect, fault;
  logic [31:0] addr, rdata, ir, ir_pc, redirect_pc;
  int tests = 0;
  int fails = 0;
  int n_gnt, exp_pc, found;

  always #5 clk = ~clk;

  // Responder grants the cycle after it sees REQ, then idles one cycle.
  always @(posedge clk) gnt_q <= rst_n && req && !gnt_q;
  assign gnt = gnt_q | stray;
  assign rdata = gnt ? (addr ^ 32'hA5A5_0000) : 32'h0;

  instr_fetch dut (
    .i_CLK(clk), .i_RSTn(rst_n),
    .o_INSTR_REQ(req), .o_INSTR_ADDR(addr), .i_INSTR_GNT(gnt), .i_INSTR_RDATA(rdata),
    .o_IR_VALID(valid), .o_IR(ir), .o_IR_PC(ir_pc), .i_IR_READY(ready),
    .i_REDIRECT(redirect), .i_REDIRECT_PC(redirect_pc), .o_FETCH_FAULT(fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    redirect = 1'b0;
    stray = 1'b0;
    ready = rdy;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = '0; stray = 1'b0;
    repeat (3) step();
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ir_pc", ir_pc, 0);
    chk("rst_fault", fault, 0);
    // streaming with a ready consumer
    rst_n = 1'b1;
    step();
    chk("c1_req", req, 1);
    chk("c1_addr", addr, 0);
    step();
    chk("c2_gnt", gnt, 1);
    chk("c2_nobypass", valid, 0);
    step();
    chk("c3_valid", valid, 1);
    chk("c3_pc", ir_pc, 0);
    chk("c3_ir", ir, 32'hA5A5_0000);
    exp_pc = 4;
    for (int c = 0; c < 40 && exp_pc < 16; c++) begin
      step();
      if (valid) begin
        chk("stream_pc", ir_pc, exp_pc);
        chk("stream_ir", ir, exp_pc ^ 32'hA5A5_0000);
        exp_pc += 4;
      end
    end
    chk("stream_done", exp_pc, 16);
    // stalled consumer fills the FIFO, stray grant ignored
    do_reset(1'b0);
    n_gnt = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (gnt && req) n_gnt++;
    end
    stray = 1'b1;
    step();
    stray = 1'b0;
    chk("stall_grants", n_gnt, 2);
    chk("stall_req", req, 0);
    chk("stall_head_pc", ir_pc, 0);
    chk("stall_head_ir", ir, 32'hA5A5_0000);
    ready = 1'b1;
    step();
    chk("pop2_pc", ir_pc, 4);
    chk("resume_req", req, 1);
    chk("resume_addr", addr, 8);
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      step();
      if (valid) begin
        chk("resume_pc", ir_pc, 8);
        found = 1;
      end
    end
    chk("resume_seen", found, 1);
    // redirect with fetch 0x8 outstanding
    do_reset(1'b1);
    repeat (5) step();
    chk("k_addr", addr, 8);
    chk("k_gnt", gnt, 0);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("k_hold_addr", addr, 8);
    chk("k_hold_gnt", gnt, 1);
    chk("k_flush", valid, 0);
    step();
    chk("k_tgt_addr", addr, 32'h100);
    chk("k_tgt_req", req, 1);
    chk("k_drop", valid, 0);
    step();
    chk("k_drop2", valid, 0);
    step();
    chk("k_valid", valid, 1);
    chk("k_pc", ir_pc, 32'h100);
    chk("k_ir", ir, 32'hA5A5_0100);
    // redirect coincident with pop and grant
    do_reset(1'b0);
    repeat (4) step();
    chk("co_gnt", gnt, 1);
    chk("co_valid", valid, 1);
    ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    chk("co_flush", valid, 0);
    chk("co_addr", addr, 32'h200);
    chk("co_req", req, 1);
    step();
    chk("co_drop", valid, 0);
    step();
    chk("co_valid2", valid, 1);
    chk("co_pc", ir_pc, 32'h200);
    // PC wrap
    do_reset(1'b1);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("w_addr", addr, 32'hFFFF_FFFC);
    chk("w_req", req, 1);
    repeat (2) step();
    chk("w_wrap_addr", addr, 0);
    chk("w_pc", ir_pc, 32'hFFFF_FFFC);
    // misaligned redirect
    do_reset(1'b1);
    redirect = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("m_fault", fault, 1);
    chk("m_req", req, 0);
    step();
    chk("m_fault_hold", fault, 1);
    chk("m_req_hold", req, 0);
    chk("m_empty", valid, 0);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    chk("m_clear", fault, 0);
    chk("m_req2", req, 1);
    chk("m_addr", addr, 32'h200);
    repeat (2) step();
    chk("m_pc", ir_pc, 32'h200);
`else
    chk("m_fault", fault, 0);
    chk("m_req", req, 1);
    chk("m_addr", addr, 32'h100);
    repeat (2) step();
    chk("m_valid", valid, 1);
    chk("m_pc", ir_pc, 32'h100);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
